line_buf_ctrl: RTL and testbench

- Sequencer for the 5-row convolution line buffer: fills the buffer from a 32-bit pixel stream, then scans it as 5-pixel vertical columns for the downstream window engine.
- Owns the buffer's only port (ce/we/addr/d), so load and scan phases are mutually exclusive.
- Sits between the AXI DMA stream and the window/MAC datapath.

---
 rtl/line_buf_ctrl.sv | 140 ++++++++++++++
 tb/tb_line_buf_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_ctrl.sv
// Line-buffer sequencer: loads a frame from a 4-pixel stream, then scans it as 5-row columns.
// Define LINE_BUF_CTRL_LAST_EN to add the m_eol / m_last column markers.
module line_buf_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 48,
  parameter int IMG_H      = 48,
  parameter int WIN        = 5,
  parameter int ADDR_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [4*DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    buf_ce,
  output logic                    buf_we,
  output logic [ADDR_W-1:0]       buf_addr,
  output logic [4*DATA_WIDTH-1:0] buf_d,
  input  logic [5*DATA_WIDTH-1:0] buf_q,
  output logic [5*DATA_WIDTH-1:0] m_col,
  output logic                    m_valid,
`ifdef LINE_BUF_CTRL_LAST_EN
  input  logic                    m_ready,
  output logic                    m_eol,
  output logic                    m_last
`else
  input  logic                    m_ready
`endif
);

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(IMG_W * IMG_H / 4 - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - WIN);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN} state_e;

  state_e                    state_q;
  logic [ADDR_W-1:0]         wr_beat_q, row_q, col_q;
  logic [ADDR_W-1:0]         wr_beat_d, row_d, col_d;
  logic [5*DATA_WIDTH-1:0]   m_col_q;
  logic                      m_valid_q, done_q, eol_q, last_q;
  logic                      accept, issue, eol_hit, final_hit;

  assign accept    = (state_q == S_LOAD) && s_valid;
  assign issue     = (state_q == S_SCAN) && (!m_valid_q || m_ready);
  assign eol_hit   = (col_q == LAST_COL);
  assign final_hit = eol_hit && (row_q == LAST_ROW);

  assign wr_beat_d = wr_beat_q + 1'b1;
  assign col_d     = eol_hit ? '0 : col_q + 1'b1;
  assign row_d     = eol_hit ? row_q + 1'b1 : row_q;

  assign busy    = (state_q == S_LOAD) || (state_q == S_SCAN);
  assign s_ready = (state_q == S_LOAD);
  assign done    = done_q;
  assign m_col   = m_col_q;
  assign m_valid = m_valid_q;
`ifdef LINE_BUF_CTRL_LAST_EN
  assign m_eol   = eol_q;
  assign m_last  = last_q;
`endif

  // The buffer port is steered straight from the stream so a write lands in the accepting cycle.
  always_comb begin
    buf_ce   = accept || issue;
    buf_we   = (state_q == S_LOAD);
    buf_addr = '0;
    buf_d    = '0;
    case (state_q)
      S_LOAD: begin
        buf_addr = {wr_beat_q[ADDR_W-3:0], 2'b00};
        buf_d    = s_data;
      end
      S_SCAN:  buf_addr = row_q * STRIDE + col_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_beat_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      m_col_q   <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
      eol_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Output register: load on issue, otherwise release only on handshake.
      if (issue) begin
        m_col_q   <= buf_q;
        m_valid_q <= 1'b1;
        eol_q     <= eol_hit;
        last_q    <= final_hit;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD;
            wr_beat_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_beat_q <= wr_beat_d;
            if (wr_beat_q == LAST_BEAT) state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (issue) begin
            col_q <= col_d;
            row_q <= row_d;
            if (final_hit) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (m_valid_q && m_ready) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: model buffer, randomized stream/ready, frame-level reference scoreboard.
`timescale 1ns/1ps
module tb_line_buf_ctrl;
  localparam int DW     = 8;
  localparam int IMG_W  = 48;
  localparam int IMG_H  = 48;
  localparam int WIN    = 5;
  localparam int ADDR_W = 12;
  localparam int BEATS  = IMG_W * IMG_H / 4;
  localparam int ROWS   = IMG_H - WIN + 1;
  localparam int NCOL   = ROWS * IMG_W;

  logic              clk = 0;
  logic              rst = 1;
  logic              start = 0;
  logic              busy, done;
  logic [4*DW-1:0]   s_data = '0;
  logic              s_valid = 0;
  logic              s_ready;
  logic              buf_ce, buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [4*DW-1:0]   buf_d;
  logic [5*DW-1:0]   buf_q;
  logic [5*DW-1:0]   m_col;
  logic              m_valid;
  logic              m_ready = 1;
`ifdef LINE_BUF_CTRL_LAST_EN
  logic              m_eol, m_last;
`endif

  line_buf_ctrl #(.DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .buf_ce(buf_ce), .buf_we(buf_we), .buf_addr(buf_addr), .buf_d(buf_d), .buf_q(buf_q),
    .m_col(m_col), .m_valid(m_valid),
`ifdef LINE_BUF_CTRL_LAST_EN
    .m_ready(m_ready), .m_eol(m_eol), .m_last(m_last)
`else
    .m_ready(m_ready)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: byte-addressed, 4-pixel write port, 5-row combinational column read.
  logic [DW-1:0] mem [0:8191];
  always @(posedge clk) begin
    if (buf_ce && buf_we)
      for (int i = 0; i < 4; i++) mem[13'(int'(buf_addr) + i)] <= buf_d[(3-i)*DW +: DW];
  end
  always_comb begin
    buf_q = '0;
    for (int j = 0; j < 5; j++) buf_q[(4-j)*DW +: DW] = mem[13'(int'(buf_addr) + j*IMG_W)];
  end

  // Reference frame: the pixels sent this frame, in raster order.
  logic [4*DW-1:0] beats [0:1023];
  logic [DW-1:0]   img   [0:4095];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5*DW-1:0] exp_col(input int idx);
    logic [5*DW-1:0] v;
    int r, c;
    r = idx / IMG_W;
    c = idx % IMG_W;
    for (int j = 0; j < 5; j++) v[(4-j)*DW +: DW] = img[12'((r + j) * IMG_W + c)];
    return v;
  endfunction

  // Monitor / scoreboard
  int              wr_cnt = 0, col_cnt = 0, done_cnt = 0, eol_cnt = 0, last_cnt = 0;
  int              last_wr_addr = 0;
  logic [5*DW-1:0] first_col = '0, last_col = '0, prev_col = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic            prev_stall = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (start && !busy && !m_valid) begin
        wr_cnt = 0; col_cnt = 0; done_cnt = 0; eol_cnt = 0; last_cnt = 0;
      end
      if (prev_stall) begin
        check("stall_hold_col", 128'(m_col), 128'(prev_col));
        check("stall_hold_valid", 128'(m_valid), 128'(1));
        check("stall_hold_addr", 128'(buf_addr), 128'(prev_addr));
      end
      if (m_valid && !m_ready) check("stall_no_ce", 128'(buf_ce), 128'(0));
      if (s_ready) check("load_ce_follows_valid", 128'({buf_ce, buf_we}), 128'({s_valid, 1'b1}));
      if (buf_ce && buf_we) begin
        check("write_in_range", 128'(wr_cnt < BEATS), 128'(1));
        check("write_addr", 128'(buf_addr), 128'(wr_cnt * 4));
        if (wr_cnt < BEATS) check("write_data", 128'(buf_d), 128'(beats[10'(wr_cnt)]));
        last_wr_addr = int'(buf_addr);
        wr_cnt++;
      end
      if (m_valid && m_ready) begin
        check("column_in_range", 128'(col_cnt < NCOL), 128'(1));
        check("column_data", 128'(m_col), 128'(exp_col(col_cnt)));
`ifdef LINE_BUF_CTRL_LAST_EN
        check("column_eol", 128'(m_eol), 128'((col_cnt % IMG_W) == IMG_W - 1));
        check("column_last", 128'(m_last), 128'(col_cnt == NCOL - 1));
        if (m_eol) eol_cnt++;
        if (m_last) last_cnt++;
`endif
        if (col_cnt == 0) first_col = m_col;
        last_col = m_col;
        col_cnt++;
      end
      if (done) begin
        check("done_after_all_columns", 128'(col_cnt), 128'(NCOL));
        check("done_valid_clear", 128'(m_valid), 128'(0));
        done_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_col   = m_col;
      prev_addr  = buf_addr;
    end
  end

  // Downstream ready: 0 = always, 1 = one on / two off, 2 = random
  int rdy_mode = 0;
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = (phase == 0); phase = (phase + 1) % 3; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic gen_frame(input bit rnd);
    for (int k = 0; k < BEATS; k++) begin
      for (int i = 0; i < 4; i++)
        beats[10'(k)][(3-i)*DW +: DW] = rnd ? DW'($urandom) : DW'(4*k + i);
      for (int i = 0; i < 4; i++) img[12'(4*k + i)] = beats[10'(k)][(3-i)*DW +: DW];
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", 128'({busy, s_ready}), 128'(2'b11));
  endtask

  // mode 0: continuous, 1: 3-cycle gap every 7 beats plus a stray start, 2: random gaps
  task automatic load_frame(input int mode);
    bit acc;
    int tmo;
    for (int k = 0; k < BEATS; k++) begin
      if (mode == 1 && k > 0 && k % 7 == 0) begin
        s_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
      end
      if (mode == 2) begin
        s_valid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      s_valid = 1;
      s_data  = beats[10'(k)];
      start   = (mode == 1 && k == 200);
      tmo = 0;
      do begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1;
        tmo++;
      end while (!acc && tmo < 8);
      start = 0;
      check("beat_accepted", 128'(acc), 128'(1));
    end
    if (mode == 0) begin
      check("scan_starts_next_cycle", 128'({buf_ce, buf_we, s_ready, busy}), 128'(4'b1001));
      check("scan_first_addr", 128'(buf_addr), 128'(0));
    end
    s_valid = 0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", 128'(done), 128'(1));
    @(posedge clk); #1;
    check("done_one_cycle", 128'({done, busy}), 128'(0));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic frame_counts();
    check("frame_writes", 128'(wr_cnt), 128'(BEATS));
    check("frame_columns", 128'(col_cnt), 128'(NCOL));
    check("frame_done_pulses", 128'(done_cnt), 128'(1));
`ifdef LINE_BUF_CTRL_LAST_EN
    check("frame_eol_count", 128'(eol_cnt), 128'(ROWS));
    check("frame_last_count", 128'(last_cnt), 128'(1));
`endif
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs_zero",
            128'({busy, done, s_ready, buf_ce, buf_we, buf_addr, buf_d, m_col, m_valid}), 128'(0));
    end
    @(posedge clk); #1;

    // Frame 1: ramp data, continuous stream, downstream always ready
    gen_frame(0);
    rdy_mode = 0;
    pulse_start();
    load_frame(0);
    wait_done();
    frame_counts();
    check("last_write_addr", 128'(last_wr_addr), 128'(2300));
    check("first_column", 128'(first_col), 128'(40'h00_30_60_90_C0));
    check("last_column", 128'(last_col), 128'(40'h3F_6F_9F_CF_FF));

    // Frame 2: random data, stream gaps, stray start, 1-on/2-off ready
    gen_frame(1);
    rdy_mode = 1;
    pulse_start();
    load_frame(1);
    wait_done();
    frame_counts();

    // Frame 3: aborted by reset mid-scan
    gen_frame(1);
    rdy_mode = 2;
    pulse_start();
    load_frame(2);
    for (int n = 0; n < 20000; n++) begin
      if (col_cnt >= 1000) break;
      @(posedge clk); #1;
    end
    check("reached_column_1000", 128'(col_cnt >= 1000), 128'(1));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("reset_mid_scan_idle",
          128'({busy, done, s_ready, buf_ce, buf_we, m_valid, buf_addr}), 128'(0));
    repeat (2) begin @(posedge clk); #1; end

    // Frame 4: full frame after the abort
    gen_frame(1);
    pulse_start();
    load_frame(2);
    wait_done();
    frame_counts();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
